// File: rtl/led_panel_pkg.sv
// Shared types and helpers for the BCM LED panel driver: FSM state
// encoding, default geometry, counter widths and pixel-field decoding.
package led_panel_pkg;

  typedef enum logic [2:0] {
    ST_FIRSTCOL = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LATCH    = 3'd3,
    ST_UNBLANK  = 3'd4,
    ST_HOLD     = 3'd5,
    ST_NEXT     = 3'd6
  } state_t;

  // Default panel geometry.
  localparam int DEF_COLS       = 32;
  localparam int DEF_ROWS       = 4;
  localparam int DEF_BPC        = 2;
  localparam int DEF_PAUSE_BASE = 4;
  localparam int DEF_ADDR_W     = $clog2(DEF_ROWS * DEF_COLS);
  localparam int DEF_PIX_W      = 3 * DEF_BPC;

  // Widest pixel the decode helper accepts (3 channels x 4 bits, plus headroom).
  localparam int PIX_MAX_W = 16;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pixel layout is {R, G, B}, each channel bpc bits wide.
  function automatic int red_lsb(input int bpc);
    return 2 * bpc;
  endfunction

  function automatic int green_lsb(input int bpc);
    return bpc;
  endfunction

  function automatic int blue_lsb(input int bpc);
    return 0 * bpc;
  endfunction

  // Pick bit 'plane' of each colour channel, returned as {r, g, b}.
  function automatic logic [2:0] pixel_plane_bits(input logic [PIX_MAX_W-1:0] pix,
                                                   input int bpc, input int plane);
    return {1'(pix >> (red_lsb(bpc) + plane)),
            1'(pix >> (green_lsb(bpc) + plane)),
            1'(pix >> (blue_lsb(bpc) + plane))};
  endfunction

endpackage

// File: rtl/led_panel_bcm_if.sv
// Frame-buffer write port: the pixel source drives it, the panel driver
// consumes it.
interface led_panel_bcm_if #(
  parameter int AW = 7,
  parameter int DW = 6
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/led_panel_fb.sv
// Frame buffer: one synchronous write port, one asynchronous read port.
// A read of the address being written in the same cycle returns the old
// word because the write only lands at the clock edge. Contents are
// deliberately not reset so a panel reset does not wipe the picture.
module led_panel_fb
  import led_panel_pkg::*;
#(
  parameter int AW = DEF_ADDR_W,
  parameter int DW = DEF_PIX_W
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_r [DEPTH];

  // Store a pixel whenever the write strobe is high, independent of the panel FSM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r[wr_addr] <= mem_r[wr_addr];
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/led_panel_bcm.sv
// HUB-style scan-multiplexed RGB panel driver using binary code modulation.
// Every scan row is shifted once per bitplane; plane b is lit for
// PAUSE_BASE<<b cycles. All panel signals come straight from registers.
module led_panel_bcm
  import led_panel_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int BPC        = DEF_BPC,
  parameter int PAUSE_BASE = DEF_PAUSE_BASE
) (
  input  logic           clk,
  input  logic           reset,
  led_panel_bcm_if.slave wr,
  output logic           red_out,
  output logic           green_out,
  output logic           blue_out,
  output logic           sclk_out,
  output logic           latch_out,
  output logic           blank_out,
  output logic           aclk_out,
  output logic           arst_out,
  output logic           frame_start
);
  localparam int COL_W  = cnt_width(COLS);
  localparam int ROW_W  = cnt_width(ROWS);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int PIX_W  = 3 * BPC;
  localparam int PL_W   = cnt_width(BPC);
  localparam int HOLD_W = cnt_width(PAUSE_BASE << (BPC - 1)) + 1;

  state_t              state_r;
  logic [COL_W-1:0]    col_r;
  logic [ROW_W-1:0]    row_r;
  logic [PL_W-1:0]     plane_r;
  logic [HOLD_W-1:0]   hold_r;
  logic                red_r, green_r, blue_r;
  logic                sclk_r, latch_r, blank_r, aclk_r, arst_r;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic [PIX_W-1:0]    rd_data_s;
  logic [2:0]          plane_rgb_s;

  // Pixel address is row*COLS + col; both dimensions are powers of two.
  assign rd_addr_s = {row_r, col_r};

  led_panel_fb #(
    .AW (ADDR_W),
    .DW (PIX_W)
  ) u_fb (
    .clk     (clk),
    .wr_en   (wr.wr_en),
    .wr_addr (wr.wr_addr),
    .wr_data (wr.wr_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Slice the current bitplane out of the pixel being addressed.
  always_comb begin
    plane_rgb_s = pixel_plane_bits(PIX_MAX_W'(rd_data_s), BPC, int'(plane_r));
  end

  // Panel sequencer: shift a row, latch it, light it for the plane's weight, advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FIRSTCOL;
      col_r   <= {COL_W{1'b0}};
      row_r   <= {ROW_W{1'b0}};
      plane_r <= {PL_W{1'b0}};
      hold_r  <= {HOLD_W{1'b0}};
      red_r   <= 1'b0;
      green_r <= 1'b0;
      blue_r  <= 1'b0;
      sclk_r  <= 1'b1;
      latch_r <= 1'b0;
      blank_r <= 1'b1;
      aclk_r  <= 1'b0;
      arst_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_FIRSTCOL: begin
          aclk_r  <= 1'b0;
          arst_r  <= 1'b0;
          col_r   <= {COL_W{1'b1}};
          state_r <= ST_SHIFT_LO;
        end
        ST_SHIFT_LO: begin
          sclk_r                    <= 1'b0;
          {red_r, green_r, blue_r}  <= plane_rgb_s;
          state_r                   <= ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          sclk_r <= 1'b1;
          if (col_r == {COL_W{1'b0}}) begin
            state_r <= ST_LATCH;
          end else begin
            col_r   <= col_r - COL_W'(1);
            state_r <= ST_SHIFT_LO;
          end
        end
        ST_LATCH: begin
          latch_r                  <= 1'b1;
          {red_r, green_r, blue_r} <= 3'b000;
          state_r                  <= ST_UNBLANK;
        end
        ST_UNBLANK: begin
          latch_r <= 1'b0;
          blank_r <= 1'b0;
          // NEXT also keeps the LEDs lit, so HOLD runs one cycle short.
          hold_r  <= HOLD_W'((PAUSE_BASE << plane_r) - 1);
          state_r <= ST_HOLD;
        end
        ST_HOLD: begin
          hold_r <= hold_r - HOLD_W'(1);
          if (hold_r == HOLD_W'(1)) begin
            state_r <= ST_NEXT;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_NEXT: begin
          blank_r <= 1'b1;
          state_r <= ST_FIRSTCOL;
          if (plane_r != PL_W'(BPC - 1)) begin
            plane_r <= plane_r + PL_W'(1);
          end else begin
            plane_r <= {PL_W{1'b0}};
            if (row_r == ROW_W'(ROWS - 1)) begin
              row_r  <= {ROW_W{1'b0}};
              arst_r <= 1'b1;
            end else begin
              row_r  <= row_r + ROW_W'(1);
              aclk_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_FIRSTCOL;
          blank_r <= 1'b1;
          latch_r <= 1'b0;
          sclk_r  <= 1'b1;
        end
      endcase
    end
  end

  assign red_out   = red_r;
  assign green_out = green_r;
  assign blue_out  = blue_r;
  assign sclk_out  = sclk_r;
  assign latch_out = latch_r;
  assign blank_out = blank_r;
  assign aclk_out  = aclk_r;
  assign arst_out  = arst_r;

  // Decoded from the state registers so the pulse lines up with the FIRSTCOL
  // cycle itself, including the very first cycle out of reset; gated by
  // reset so it stays low while reset is held.
  assign frame_start = ~reset & (state_r == ST_FIRSTCOL) &
                       (row_r == {ROW_W{1'b0}}) & (plane_r == {PL_W{1'b0}});

endmodule
